// File: rtl/cache_update_pkg.sv
// Shared definitions for the cache update (write-side) path: command
// type codes, FSM state encodings and default array geometry.
package cache_update_pkg;

   localparam int CACHE_INDEX_W = 7;
   localparam int SRAM_TAG_W    = 8;
   localparam int SRAM_DATA_W   = 32;
   localparam int SRAM_ADDR_W   = 8;

   typedef enum logic [1:0] {
      UPD_TOUCH  = 2'd0,
      UPD_WHIT   = 2'd1,
      UPD_REFILL = 2'd2,
      UPD_INVAL  = 2'd3
   } upd_type_e;

   typedef enum logic [1:0] {
      UPD_IDLE  = 2'd0,
      UPD_ARB   = 2'd1,
      UPD_WRITE = 2'd2,
      UPD_DONE  = 2'd3
   } upd_state_e;

   // Only commands that touch the tag/data SRAMs go through the arbiter.
   function automatic logic upd_needs_sram(input logic [1:0] t);
      return (t == UPD_WHIT) || (t == UPD_REFILL);
   endfunction

endpackage

// File: rtl/cache_update_way_dec.sv
// Per-way strobe decode: turns (way, command type, in-WRITE) into the
// SRAM enables and valid/dirty array write enables for each way.
module cache_update_way_dec
   import cache_update_pkg::*;
(
   input  logic       wr,
   input  logic       way,
   input  logic [1:0] typ,
   output logic [1:0] data_en,
   output logic [1:0] tag_en,
   output logic [1:0] value_wen,
   output logic [1:0] dirty_wen,
   output logic       lru_wen
);

   logic uses_data, uses_tag, uses_value, uses_dirty;

   // Which arrays each command type writes.
   always_comb begin
      uses_data  = (typ == UPD_WHIT) || (typ == UPD_REFILL);
      uses_tag   = (typ == UPD_REFILL);
      uses_value = (typ == UPD_REFILL) || (typ == UPD_INVAL);
      uses_dirty = (typ != UPD_TOUCH);
   end

   // Every command updates LRU, so it only needs the WRITE qualifier.
   assign lru_wen = wr;

   for (genvar w = 0; w < 2; w++) begin : g_way
      logic sel;
      assign sel          = wr && (way == 1'(w));
      assign data_en[w]   = sel && uses_data;
      assign tag_en[w]    = sel && uses_tag;
      assign value_wen[w] = sel && uses_value;
      assign dirty_wen[w] = sel && uses_dirty;
   end

endmodule

// File: rtl/cache_update.sv
// Cache update path: captures one update command (TOUCH/WHIT/REFILL/INVAL),
// arbitrates for the SRAM ports when needed and performs a single-cycle
// write into the tag/data SRAMs and the valid/dirty/LRU arrays.
// Optional: define CACHE_UPD_ERR_EN to add the sticky upd_err flag and the
// upd_value_chk input.
module cache_update
   import cache_update_pkg::*;
#(
   parameter int INDEX_W = CACHE_INDEX_W,
   parameter int TAG_W   = SRAM_TAG_W,
   parameter int DATA_W  = SRAM_DATA_W,
   parameter int ADDR_W  = SRAM_ADDR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               upd_req,
   input  logic [1:0]         upd_type,
   input  logic               upd_way,
   input  logic [INDEX_W-1:0] upd_index,
   input  logic [TAG_W-1:0]   upd_tag,
   input  logic [DATA_W-1:0]  upd_wdata,
   input  logic               upd_dirty,
   output logic               upd_busy,
   output logic               upd_done,
   output logic               upd_arb,
   input  logic               upd_gnt,
   output logic               upd_data_cen0,
   output logic               upd_data_wen0,
   output logic [ADDR_W-1:0]  upd_data_addr0,
   output logic [DATA_W-1:0]  upd_data_wdata0,
   output logic               upd_data_cen1,
   output logic               upd_data_wen1,
   output logic [ADDR_W-1:0]  upd_data_addr1,
   output logic [DATA_W-1:0]  upd_data_wdata1,
   output logic               upd_tag_cen0,
   output logic               upd_tag_wen0,
   output logic [ADDR_W-1:0]  upd_tag_addr0,
   output logic [TAG_W-1:0]   upd_tag_wdata0,
   output logic               upd_tag_cen1,
   output logic               upd_tag_wen1,
   output logic [ADDR_W-1:0]  upd_tag_addr1,
   output logic [TAG_W-1:0]   upd_tag_wdata1,
   output logic               upd_value_wen0,
   output logic               upd_value_wen1,
   output logic [INDEX_W-1:0] upd_value_waddr,
   output logic               upd_value_wdata,
   output logic               upd_dirty_wen0,
   output logic               upd_dirty_wen1,
   output logic [INDEX_W-1:0] upd_dirty_waddr,
   output logic               upd_dirty_wdata,
   output logic               upd_lru_wen,
   output logic [INDEX_W-1:0] upd_lru_waddr,
   output logic               upd_lru_wdata
`ifdef CACHE_UPD_ERR_EN
   ,
   input  logic               upd_value_chk,
   output logic               upd_err
`endif
);

   upd_state_e         state;
   logic [1:0]         cmd_type;
   logic               cmd_way;
   logic [INDEX_W-1:0] cmd_index;
   logic [TAG_W-1:0]   cmd_tag;
   logic [DATA_W-1:0]  cmd_wdata;
   logic               cmd_dirty;

   logic               wr;
   logic [1:0]         data_en, tag_en, value_wen, dirty_wen;
   logic [ADDR_W-1:0]  sram_addr;
   logic [INDEX_W-1:0] arr_addr;

   // Command capture and sequencing; requests are only accepted in IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= UPD_IDLE;
         cmd_type  <= UPD_TOUCH;
         cmd_way   <= 1'b0;
         cmd_index <= '0;
         cmd_tag   <= '0;
         cmd_wdata <= '0;
         cmd_dirty <= 1'b0;
      end else begin
         case (state)
            UPD_IDLE: if (upd_req) begin
               cmd_type  <= upd_type;
               cmd_way   <= upd_way;
               cmd_index <= upd_index;
               cmd_tag   <= upd_tag;
               cmd_wdata <= upd_wdata;
               cmd_dirty <= upd_dirty;
               state     <= upd_needs_sram(upd_type) ? UPD_ARB : UPD_WRITE;
            end
            UPD_ARB:   if (upd_gnt) state <= UPD_WRITE;
            UPD_WRITE: state <= UPD_DONE;
            default:   state <= UPD_IDLE;
         endcase
      end
   end

`ifdef CACHE_UPD_ERR_EN
   // Sticky error: request while busy, or write hit on a line reported invalid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         upd_err <= 1'b0;
      else if (upd_req && (upd_busy ||
               (upd_type == UPD_WHIT && !upd_value_chk)))
         upd_err <= 1'b1;
   end
`endif

   assign wr       = (state == UPD_WRITE);
   assign upd_busy = (state != UPD_IDLE);
   assign upd_done = (state == UPD_DONE);
   assign upd_arb  = (state == UPD_ARB);

   cache_update_way_dec u_way_dec (
      .wr        (wr),
      .way       (cmd_way),
      .typ       (cmd_type),
      .data_en   (data_en),
      .tag_en    (tag_en),
      .value_wen (value_wen),
      .dirty_wen (dirty_wen),
      .lru_wen   (upd_lru_wen)
   );

   // Addresses and write data are held at zero outside the WRITE cycle.
   always_comb begin
      sram_addr = wr ? ADDR_W'(cmd_index) : '0;
      arr_addr  = wr ? cmd_index : '0;
   end

   assign upd_data_cen0   = data_en[0];
   assign upd_data_wen0   = data_en[0];
   assign upd_data_cen1   = data_en[1];
   assign upd_data_wen1   = data_en[1];
   assign upd_data_addr0  = sram_addr;
   assign upd_data_addr1  = sram_addr;
   assign upd_data_wdata0 = wr ? cmd_wdata : '0;
   assign upd_data_wdata1 = wr ? cmd_wdata : '0;

   assign upd_tag_cen0    = tag_en[0];
   assign upd_tag_wen0    = tag_en[0];
   assign upd_tag_cen1    = tag_en[1];
   assign upd_tag_wen1    = tag_en[1];
   assign upd_tag_addr0   = sram_addr;
   assign upd_tag_addr1   = sram_addr;
   assign upd_tag_wdata0  = wr ? cmd_tag : '0;
   assign upd_tag_wdata1  = wr ? cmd_tag : '0;

   assign upd_value_wen0  = value_wen[0];
   assign upd_value_wen1  = value_wen[1];
   assign upd_value_waddr = arr_addr;
   assign upd_value_wdata = wr && (cmd_type == UPD_REFILL);

   assign upd_dirty_wen0  = dirty_wen[0];
   assign upd_dirty_wen1  = dirty_wen[1];
   assign upd_dirty_waddr = arr_addr;
   assign upd_dirty_wdata = wr && ((cmd_type == UPD_WHIT) ||
                                   (cmd_type == UPD_REFILL && cmd_dirty));

   // LRU stores the MRU way; INVAL points it away from the dropped way.
   assign upd_lru_waddr   = arr_addr;
   assign upd_lru_wdata   = wr && ((cmd_type == UPD_INVAL) ? !cmd_way : cmd_way);

endmodule

// File: tb/tb_cache_update.sv
// Self-checking bench for cache_update: directed cases plus random command
// streams, checked against an array-level model of the cache state.
module tb_cache_update;
   import cache_update_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        upd_req, upd_way, upd_dirty, upd_gnt;
   logic [1:0]  upd_type;
   logic [6:0]  upd_index;
   logic [7:0]  upd_tag;
   logic [31:0] upd_wdata;
   logic        upd_busy, upd_done, upd_arb;
   logic        upd_data_cen0, upd_data_wen0, upd_data_cen1, upd_data_wen1;
   logic [7:0]  upd_data_addr0, upd_data_addr1;
   logic [31:0] upd_data_wdata0, upd_data_wdata1;
   logic        upd_tag_cen0, upd_tag_wen0, upd_tag_cen1, upd_tag_wen1;
   logic [7:0]  upd_tag_addr0, upd_tag_addr1;
   logic [7:0]  upd_tag_wdata0, upd_tag_wdata1;
   logic        upd_value_wen0, upd_value_wen1, upd_value_wdata;
   logic [6:0]  upd_value_waddr, upd_dirty_waddr, upd_lru_waddr;
   logic        upd_dirty_wen0, upd_dirty_wen1, upd_dirty_wdata;
   logic        upd_lru_wen, upd_lru_wdata;
`ifdef CACHE_UPD_ERR_EN
   logic        upd_value_chk, upd_err;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   cache_update dut (
      .clk(clk), .reset(reset), .upd_req(upd_req), .upd_type(upd_type),
      .upd_way(upd_way), .upd_index(upd_index), .upd_tag(upd_tag),
      .upd_wdata(upd_wdata), .upd_dirty(upd_dirty), .upd_busy(upd_busy),
      .upd_done(upd_done), .upd_arb(upd_arb), .upd_gnt(upd_gnt),
      .upd_data_cen0(upd_data_cen0), .upd_data_wen0(upd_data_wen0),
      .upd_data_addr0(upd_data_addr0), .upd_data_wdata0(upd_data_wdata0),
      .upd_data_cen1(upd_data_cen1), .upd_data_wen1(upd_data_wen1),
      .upd_data_addr1(upd_data_addr1), .upd_data_wdata1(upd_data_wdata1),
      .upd_tag_cen0(upd_tag_cen0), .upd_tag_wen0(upd_tag_wen0),
      .upd_tag_addr0(upd_tag_addr0), .upd_tag_wdata0(upd_tag_wdata0),
      .upd_tag_cen1(upd_tag_cen1), .upd_tag_wen1(upd_tag_wen1),
      .upd_tag_addr1(upd_tag_addr1), .upd_tag_wdata1(upd_tag_wdata1),
      .upd_value_wen0(upd_value_wen0), .upd_value_wen1(upd_value_wen1),
      .upd_value_waddr(upd_value_waddr), .upd_value_wdata(upd_value_wdata),
      .upd_dirty_wen0(upd_dirty_wen0), .upd_dirty_wen1(upd_dirty_wen1),
      .upd_dirty_waddr(upd_dirty_waddr), .upd_dirty_wdata(upd_dirty_wdata),
      .upd_lru_wen(upd_lru_wen), .upd_lru_waddr(upd_lru_waddr),
      .upd_lru_wdata(upd_lru_wdata)
`ifdef CACHE_UPD_ERR_EN
      , .upd_value_chk(upd_value_chk), .upd_err(upd_err)
`endif
   );

   // All write strobes in one vector: data1, data0, tag1, tag0, value, dirty, lru.
   logic [12:0] stb;
   assign stb = {upd_data_cen1, upd_data_wen1, upd_data_cen0, upd_data_wen0,
                 upd_tag_cen1, upd_tag_wen1, upd_tag_cen0, upd_tag_wen0,
                 upd_value_wen1, upd_value_wen0, upd_dirty_wen1, upd_dirty_wen0,
                 upd_lru_wen};

   logic any_out;
   assign any_out = |{upd_busy, upd_done, upd_arb, stb, upd_data_addr0,
                      upd_data_addr1, upd_data_wdata0, upd_data_wdata1,
                      upd_tag_addr0, upd_tag_addr1, upd_tag_wdata0, upd_tag_wdata1,
                      upd_value_waddr, upd_value_wdata, upd_dirty_waddr,
                      upd_dirty_wdata, upd_lru_waddr, upd_lru_wdata
`ifdef CACHE_UPD_ERR_EN
                      , upd_err
`endif
                      };

   // Storage driven by the DUT's strobes (what the real arrays would hold).
   logic        clr;
   logic [31:0] d_data  [2][128];
   logic [7:0]  d_tag   [2][128];
   logic        d_valid [2][128];
   logic        d_dirty [2][128];
   logic        d_lru   [128];

   // Reference cache state, updated from command semantics.
   logic [31:0] m_data  [2][128];
   logic [7:0]  m_tag   [2][128];
   logic        m_valid [2][128];
   logic        m_dirty [2][128];
   logic        m_lru   [128];

   // Emulate the external SRAMs and register arrays.
   always @(posedge clk) begin
      if (clr) begin
         for (int w = 0; w < 2; w++)
            for (int i = 0; i < 128; i++) begin
               d_data[w][i] <= '0; d_tag[w][i] <= '0;
               d_valid[w][i] <= 1'b0; d_dirty[w][i] <= 1'b0;
            end
         for (int i = 0; i < 128; i++) d_lru[i] <= 1'b0;
      end else begin
         if (upd_data_cen0 && upd_data_wen0) d_data[0][upd_data_addr0[6:0]] <= upd_data_wdata0;
         if (upd_data_cen1 && upd_data_wen1) d_data[1][upd_data_addr1[6:0]] <= upd_data_wdata1;
         if (upd_tag_cen0 && upd_tag_wen0)   d_tag[0][upd_tag_addr0[6:0]]   <= upd_tag_wdata0;
         if (upd_tag_cen1 && upd_tag_wen1)   d_tag[1][upd_tag_addr1[6:0]]   <= upd_tag_wdata1;
         if (upd_value_wen0) d_valid[0][upd_value_waddr] <= upd_value_wdata;
         if (upd_value_wen1) d_valid[1][upd_value_waddr] <= upd_value_wdata;
         if (upd_dirty_wen0) d_dirty[0][upd_dirty_waddr] <= upd_dirty_wdata;
         if (upd_dirty_wen1) d_dirty[1][upd_dirty_waddr] <= upd_dirty_wdata;
         if (upd_lru_wen)    d_lru[upd_lru_waddr]        <= upd_lru_wdata;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_set(input logic [6:0] idx);
      for (int w = 0; w < 2; w++) begin
         chk("valid", 64'(d_valid[w][idx]), 64'(m_valid[w][idx]));
         chk("dirty", 64'(d_dirty[w][idx]), 64'(m_dirty[w][idx]));
         chk("tag",   64'(d_tag[w][idx]),   64'(m_tag[w][idx]));
         chk("data",  64'(d_data[w][idx]),  64'(m_data[w][idx]));
      end
      chk("lru", 64'(d_lru[idx]), 64'(m_lru[idx]));
   endtask

   // Issue one command; gdly = grant-low cycles; spur = extra req while busy.
   task automatic run_cmd(input logic [1:0] typ, input logic way, input logic [6:0] idx,
                          input logic [7:0] tag, input logic [31:0] wd, input logic dty,
                          input int gdly, input bit spur);
      logic sram, d, t, v, dr;
      logic [6:0] sidx;
      logic [12:0] exp_stb;
      sram = (typ == UPD_WHIT) || (typ == UPD_REFILL);
      sidx = idx ^ 7'h40;
      upd_req = 1'b1; upd_type = typ; upd_way = way; upd_index = idx;
      upd_tag = tag; upd_wdata = wd; upd_dirty = dty; upd_gnt = (gdly == 0);
      @(posedge clk); #1;
      // Scramble inputs: the DUT must work from its captured command.
      upd_req = 1'b0; upd_way = ~way; upd_tag = 8'($urandom);
      upd_wdata = $urandom; upd_dirty = ~dty;
      if (sram) begin
         for (int k = 0; k <= gdly; k++) begin
            upd_gnt = (k == gdly);
            upd_req = spur && (k == 0);
            upd_type = UPD_INVAL; upd_index = sidx;
            chk("arb", 64'(upd_arb), 64'd1);
            chk("arb_busy", 64'(upd_busy), 64'd1);
            chk("arb_nostb", 64'(stb), 64'd0);
            chk("arb_addr", 64'(upd_data_addr0), 64'd0);
            @(posedge clk); #1;
         end
      end
      upd_gnt = 1'b0;
      upd_req = spur && !sram; upd_type = UPD_INVAL; upd_index = sidx;
      d = sram; t = (typ == UPD_REFILL);
      v = (typ == UPD_REFILL) || (typ == UPD_INVAL); dr = (typ != UPD_TOUCH);
      exp_stb = {d && way, d && way, d && !way, d && !way, t && way, t && way,
                 t && !way, t && !way, v && way, v && !way, dr && way, dr && !way, 1'b1};
      chk("wr_stb", 64'(stb), 64'(exp_stb));
      chk("wr_arb", 64'(upd_arb), 64'd0);
      chk("wr_done", 64'(upd_done), 64'd0);
      chk("wr_daddr", 64'(way ? upd_data_addr1 : upd_data_addr0), 64'(idx));
      chk("wr_laddr", 64'(upd_lru_waddr), 64'(idx));
      chk("wr_lru", 64'(upd_lru_wdata), 64'((typ == UPD_INVAL) ? !way : way));
      @(posedge clk); #1;
      upd_req = 1'b0;
      chk("done", 64'(upd_done), 64'd1);
      chk("done_stb", 64'(stb), 64'd0);
      @(posedge clk); #1;
      chk("idle", 64'({upd_done, upd_busy}), 64'd0);
      case (typ)
         UPD_TOUCH: m_lru[idx] = way;
         UPD_WHIT: begin
            m_data[way][idx] = wd; m_dirty[way][idx] = 1'b1; m_lru[idx] = way;
         end
         UPD_REFILL: begin
            m_data[way][idx] = wd; m_tag[way][idx] = tag;
            m_valid[way][idx] = 1'b1; m_dirty[way][idx] = dty; m_lru[idx] = way;
         end
         default: begin
            m_valid[way][idx] = 1'b0; m_dirty[way][idx] = 1'b0; m_lru[idx] = !way;
         end
      endcase
      chk_set(idx);
      if (spur) chk_set(sidx);
   endtask

   initial begin
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < 128; i++) begin
            m_data[w][i] = '0; m_tag[w][i] = '0;
            m_valid[w][i] = 1'b0; m_dirty[w][i] = 1'b0;
         end
      for (int i = 0; i < 128; i++) m_lru[i] = 1'b0;
      reset = 1'b1; clr = 1'b1;
      upd_req = 1'b0; upd_type = '0; upd_way = 1'b0; upd_index = '0;
      upd_tag = '0; upd_wdata = '0; upd_dirty = 1'b0; upd_gnt = 1'b0;
`ifdef CACHE_UPD_ERR_EN
      upd_value_chk = 1'b1;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", 64'(any_out), 64'd0);
      reset = 1'b0; clr = 1'b0;
      @(posedge clk); #1;

      // Directed cases.
      run_cmd(UPD_TOUCH,  1'b1, 7'h05, 8'h00, 32'h0, 1'b0, 0, 1'b0);
      run_cmd(UPD_REFILL, 1'b0, 7'h12, 8'h3A, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
      run_cmd(UPD_WHIT,   1'b1, 7'h12, 8'h00, 32'h1234_5678, 1'b0, 4, 1'b0);
      run_cmd(UPD_INVAL,  1'b0, 7'h7F, 8'h00, 32'h0, 1'b0, 0, 1'b0);
`ifdef CACHE_UPD_ERR_EN
      chk("err_clean", 64'(upd_err), 64'd0);
`endif
      // Requests while busy are dropped.
      run_cmd(UPD_WHIT,  1'b0, 7'h12, 8'h00, 32'hCAFE_F00D, 1'b0, 1, 1'b1);
      run_cmd(UPD_TOUCH, 1'b0, 7'h33, 8'h00, 32'h0, 1'b0, 0, 1'b1);
`ifdef CACHE_UPD_ERR_EN
      chk("err_set", 64'(upd_err), 64'd1);
      run_cmd(UPD_TOUCH, 1'b1, 7'h34, 8'h00, 32'h0, 1'b0, 0, 1'b0);
      chk("err_sticky", 64'(upd_err), 64'd1);
`endif

      // Reset during ARB aborts the command with no array write.
      upd_req = 1'b1; upd_type = UPD_REFILL; upd_way = 1'b1; upd_index = 7'h21;
      upd_tag = 8'h55; upd_wdata = 32'hAAAA_5555; upd_dirty = 1'b1; upd_gnt = 1'b0;
      @(posedge clk); #1;
      upd_req = 1'b0;
      chk("abort_arb", 64'(upd_arb), 64'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("abort_out", 64'(any_out), 64'd0);
      upd_gnt = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("abort_hold", 64'(any_out), 64'd0);
      reset = 1'b0; upd_gnt = 1'b0;
      @(posedge clk); #1;
      chk_set(7'h21);
      run_cmd(UPD_TOUCH, 1'b0, 7'h21, 8'h00, 32'h0, 1'b0, 0, 1'b0);

      // Random command stream over a small set range to force reuse.
      for (int n = 0; n < 60; n++)
         run_cmd(2'($urandom_range(0, 3)), 1'($urandom), 7'($urandom_range(0, 15)),
                 8'($urandom), $urandom, 1'($urandom), $urandom_range(0, 3),
                 ($urandom_range(0, 7) == 0));

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
